// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//
// Fetch-stage sequencer. It owns the program counter and keeps at most one
// instruction-memory request in flight. Each returned instruction goes to the
// external fetch mini decoder. The decoder's flags and immediate choose the
// next PC using static prediction: backward branches, jal and jalr are
// predicted taken. The instruction, its PC and the prediction bit are handed
// to decode over a valid/ready interface. An execute-stage flush redirects
// fetch from any state.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ifu_req_*               request channel to instruction memory
//   ifu_rsp_*               response channel (one response per accepted req)
//   dec_*                   mini-decoder results for ifu_rsp_instr_i
//   jalr_rs1_*              regfile read of the jalr base register
//   ifu_o_*                 instruction hand-off to decode (valid/ready)
//   exu_flush_i/_pc_i       execute redirect and its target
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module fetch_pc_ctrl #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      ifu_req_valid_o,
  input  logic                      ifu_req_ready_i,
  output logic [`XLEN-1:0]          ifu_req_addr_o,
  input  logic                      ifu_rsp_valid_i,
  input  logic [`INSTR_WIDTH-1:0]   ifu_rsp_instr_i,
  input  logic                      dec_bxx_i,
  input  logic                      dec_jal_i,
  input  logic                      dec_jalr_i,
  input  logic [`REG_IDX_WIDTH-1:0] dec_jalr_rs1_idx_i,
  input  logic [`XLEN-1:0]          dec_bjp_imm_i,
  output logic                      jalr_rs1_req_o,
  output logic [`REG_IDX_WIDTH-1:0] jalr_rs1_idx_o,
  input  logic                      jalr_rs1_vld_i,
  input  logic [`XLEN-1:0]          jalr_rs1_val_i,
  output logic                      ifu_o_valid_o,
  input  logic                      ifu_o_ready_i,
  output logic [`INSTR_WIDTH-1:0]   ifu_o_instr_o,
  output logic [`XLEN-1:0]          ifu_o_pc_o,
  output logic                      ifu_o_pred_taken_o,
  input  logic                      exu_flush_i,
  input  logic [`XLEN-1:0]          exu_flush_pc_i
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_JALR,
    S_DROP
  } state_t;

  state_t                      r_state;
  logic [`XLEN-1:0]            r_pc;
  logic [`XLEN-1:0]            r_jalr_imm;
  logic                        r_is_jalr;
  logic                        r_jalr_req;
  logic [`REG_IDX_WIDTH-1:0]   r_jalr_idx;
  logic                        r_o_valid;
  logic [`INSTR_WIDTH-1:0]     r_o_instr;
  logic [`XLEN-1:0]            r_o_pc;
  logic                        r_o_pred;

  logic [`XLEN-1:0]            w_pc_plus4;
  logic [`XLEN-1:0]            w_pc_plus_imm;
  logic [`XLEN-1:0]            w_jalr_target;
  logic [`XLEN-1:0]            w_next_pc;
  logic                        w_pred;

  // Candidate PCs. The adds wrap naturally at XLEN bits. The jalr target
  // clears bit 0, as the ISA requires.
  assign w_pc_plus4    = r_pc + `XLEN'(4);
  assign w_pc_plus_imm = r_pc + dec_bjp_imm_i;
  assign w_jalr_target = (jalr_rs1_val_i + r_jalr_imm) & ~`XLEN'(1);

  // Static prediction from the decoder flags. A conditional branch is
  // predicted taken only when its immediate is negative (a backward loop).
  // For jalr the PC is parked here because the real target is only known
  // once the base register has been read.
  always_comb begin
    w_next_pc = w_pc_plus4;
    w_pred    = 1'b0;
    if (dec_jalr_i) begin
      w_next_pc = r_pc;
      w_pred    = 1'b1;
    end else if (dec_jal_i) begin
      w_next_pc = w_pc_plus_imm;
      w_pred    = 1'b1;
    end else if (dec_bxx_i && dec_bjp_imm_i[`XLEN-1]) begin
      w_next_pc = w_pc_plus_imm;
      w_pred    = 1'b1;
    end
  end

  // The request is combinational from the state. The address is the PC
  // register, so it stays stable until the request is accepted. A flush
  // that lands in the same cycle as decode's ready blocks the hand-off:
  // the valid is masked immediately, not one cycle later.
  assign ifu_req_valid_o    = (r_state == S_REQ);
  assign ifu_req_addr_o     = r_pc;
  assign ifu_o_valid_o      = r_o_valid & ~exu_flush_i;
  assign ifu_o_instr_o      = r_o_instr;
  assign ifu_o_pc_o         = r_o_pc;
  assign ifu_o_pred_taken_o = r_o_pred;
  assign jalr_rs1_req_o     = r_jalr_req;
  assign jalr_rs1_idx_o     = r_jalr_idx;

  // Main sequencer. A flush overrides everything else. Where a request has
  // already been accepted but its response has not yet returned, the
  // sequencer goes to DROP so the stale response is discarded. A flush
  // inside DROP only retargets the PC; the pending response still has to
  // be drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_jalr_imm <= '0;
      r_is_jalr  <= 1'b0;
      r_jalr_req <= 1'b0;
      r_jalr_idx <= '0;
      r_o_valid  <= 1'b0;
      r_o_instr  <= '0;
      r_o_pc     <= '0;
      r_o_pred   <= 1'b0;
    end else if (exu_flush_i) begin
      r_pc       <= exu_flush_pc_i;
      r_o_valid  <= 1'b0;
      r_jalr_req <= 1'b0;
      case (r_state)
        S_REQ:   r_state <= ifu_req_ready_i ? S_DROP : S_REQ;
        S_WAIT:  r_state <= ifu_rsp_valid_i ? S_REQ : S_DROP;
        S_DROP:  r_state <= ifu_rsp_valid_i ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (ifu_req_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (ifu_rsp_valid_i) begin
            r_o_instr <= ifu_rsp_instr_i;
            r_o_pc    <= r_pc;
            r_o_pred  <= w_pred;
            r_o_valid <= 1'b1;
            r_pc      <= w_next_pc;
            r_is_jalr <= dec_jalr_i;
            if (dec_jalr_i) begin
              r_jalr_idx <= dec_jalr_rs1_idx_i;
              r_jalr_imm <= dec_bjp_imm_i;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ifu_o_ready_i) begin
            r_o_valid <= 1'b0;
            if (r_is_jalr) begin
              r_jalr_req <= 1'b1;
              r_state    <= S_JALR;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_JALR: begin
          if (jalr_rs1_vld_i) begin
            r_pc       <= w_jalr_target;
            r_jalr_req <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (ifu_rsp_valid_i) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
